dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder that answers the load/store requests the single-cycle RV64 datapath issues from its memory stage. It accepts one request per transaction through a valid/ready handshake and holds it in a small FSM. After a fixed wait it commits stores with byte lanes, or returns sign- or zero-extended load data. While a transaction is outstanding it asserts `stall` so the core freezes its PC.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: number of 64-bit words; valid byte addresses are 0 to 8*DEPTH_WORDS-1.
- `LATENCY`, 2: cycles from the accept edge to the `rsp_valid` cycle; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the rising edge of `clk`.
- `req_valid`  in  1  core presents a memory operation (MemRead | MemWrite).
- `req_ready`  out  1  responder can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  64  byte address (ALU result).
- `req_wdata`  in  64  store data (rs2 value); low bytes are used per size.
- `req_size`  in  3  funct3 encoding: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu; 111 is illegal.
- `rsp_valid`  out  1  one-cycle pulse when the transaction completes.
- `rsp_rdata`  out  64  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  qualified by `rsp_valid`; set on misaligned access, out-of-range access, or illegal size.
- `stall`  out  1  core must hold its PC and register writeback.

## Operation
- FSM has three states: IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid` the request is accepted: write, addr, wdata and size are captured.
  - The wait counter is loaded with LATENCY-1.
  - Next state is WAIT if LATENCY > 1, otherwise RESP.
- **WAIT**
  - Counter decrements each cycle; at 0 the FSM moves to RESP.
  - `req_*` inputs are ignored.
- **RESP**
  - `rsp_valid` = 1 for exactly this cycle; next state is IDLE.
  - `req_ready` = 0, so a request held high by the core is not re-accepted here.
- **Store commit:** on the edge entering RESP, only the addressed bytes are written; all other bytes are preserved.
- **Load data:** read on the edge entering RESP from the captured address.
- **Byte order:** little-endian. Byte offset = addr[2:0]; word index = addr[63:3].
- **Extension:** b/h/w loads sign-extend to 64 bits; bu/hu/wu loads zero-extend; d loads are passed through unchanged.
- **Errors:** an access is an error if any of the following holds:
  - the address is not aligned to its size;
  - the word index is ≥ DEPTH_WORDS;
  - `req_size` = 111;
  - a store uses size 100/101/110.
- **On error:** no array write occurs, `rsp_rdata` = 0, `rsp_err` = 1.
- **Stall:** `stall` = (IDLE & `req_valid`) | WAIT. It is 0 in RESP, so the core advances on the edge ending RESP.
- **Reset (`reset` = 0 at an edge):**
  - FSM goes to IDLE; counter and captured request are cleared.
  - All outputs go to 0, except `req_ready`, which goes to 1.
  - The whole array is cleared to 0.
  - A store still in WAIT is discarded, never committed.
  - Reset has priority over every other event.

## Timing
- Accept edge is T. `rsp_valid` is high during cycle T+LATENCY.
- `req_ready` is high again at T+LATENCY+1. Maximum throughput is one request per LATENCY+1 cycles.
- A load accepted after a store's RESP cycle observes that store's data.
- The `stall` path from `req_valid` to `stall` is combinational. All other outputs are registered or decoded from state.
- Outputs after reset: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `stall`=0 (while `req_valid`=0).

## Structure
- Shared package `dmem_pkg`:
  - size encodings (SZ_B … SZ_WU);
  - FSM state enum (S_IDLE, S_WAIT, S_RESP);
  - error-check function for size vs. addr[2:0].
- Sub-module `dmem_lane_align`, combinational:
  - store path: given size, offset and wdata, produces the byte-enable mask and shifted write data;
  - load path: given size, offset and the raw word, produces the extended load data.
- The top level holds the FSM, the counter, the capture registers and the storage array.

## Test plan
- Reset, then store d 0x1122334455667788 at addr 0x10, then load d at 0x10 → `rsp_valid` at T+2; `rsp_rdata` = 0x1122334455667788; `rsp_err` = 0.
- Store b 0x80 at 0x13, then load b at 0x13 → 0xFFFFFFFFFFFFFF80; load bu at 0x13 → 0x80; load d at 0x10 → 0x1122334480667788.
- Load w at 0x12 (misaligned) → `rsp_err` = 1, `rsp_rdata` = 0. Store at 8*DEPTH_WORDS → `rsp_err` = 1 and no array change.
- Hold `req_valid` high continuously with LATENCY=3 → `stall` high for 3 cycles, low in the RESP cycle; second accept occurs exactly 4 cycles after the first.
- Assert `reset` while a store to 0x20 is in WAIT → no `rsp_valid`; a subsequent load d at 0x20 returns 0.
- LATENCY=1 → `rsp_valid` one cycle after accept with no WAIT state; `stall` high for exactly 1 cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings, FSM states and access-check helpers shared by dmem_responder
package dmem_pkg;
    typedef enum logic [2:0] {
        SZ_B   = 3'b000,
        SZ_H   = 3'b001,
        SZ_W   = 3'b010,
        SZ_D   = 3'b011,
        SZ_BU  = 3'b100,
        SZ_HU  = 3'b101,
        SZ_WU  = 3'b110,
        SZ_ILL = 3'b111
    } size_e;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
    // size[1:0] gives log2 of the access width for both signed and unsigned loads
    function automatic logic misaligned(input logic [2:0] size, input logic [2:0] off);
        return size[1:0] == 2'b00 ? 1'b0 :
               size[1:0] == 2'b01 ? off[0] :
               size[1:0] == 2'b10 ? |off[1:0] : |off;
    endfunction
    function automatic logic access_err(input logic write, input logic [2:0] size, input logic [2:0] off);
        return misaligned(size, off) || size == SZ_ILL || (write && size[2]);
    endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for stores and extension of load data
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [2:0]  off,
    input  logic [63:0] wdata,
    input  logic [63:0] rword,
    output logic [7:0]  be,
    output logic [63:0] wdata_sh,
    output logic [63:0] rdata
);
    logic [7:0]  be_base;
    logic [63:0] rsh;
    always_comb begin
        be_base  = size[1:0] == 2'b00 ? 8'h01 :
                   size[1:0] == 2'b01 ? 8'h03 :
                   size[1:0] == 2'b10 ? 8'h0F : 8'hFF;
        be       = be_base << off;
        wdata_sh = wdata << {off, 3'b000};
        rsh      = rword >> {off, 3'b000};
        rdata    = size == SZ_B  ? {{56{rsh[7]}}, rsh[7:0]} :
                   size == SZ_H  ? {{48{rsh[15]}}, rsh[15:0]} :
                   size == SZ_W  ? {{32{rsh[31]}}, rsh[31:0]} :
                   size == SZ_BU ? {56'd0, rsh[7:0]} :
                   size == SZ_HU ? {48'd0, rsh[15:0]} :
                   size == SZ_WU ? {32'd0, rsh[31:0]} : rsh;
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency load/store responder for the memory stage, stalling the core
// while a transaction is outstanding.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);
    localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [63:0]   addr_q, addr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [2:0]    size_q, size_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [63:0]   mem_q [DEPTH_WORDS];
    logic          op_write, op_err, commit;
    logic [63:0]   op_addr, op_wdata, raw, merged, wsh, rext;
    logic [2:0]    op_size;
    logic [IW-1:0] idx;
    logic [7:0]    be;
    // With LATENCY=1 the commit edge is the accept edge, so the live request is used in IDLE
    always_comb begin
        op_write = state_q == S_IDLE ? req_write : write_q;
        op_addr  = state_q == S_IDLE ? req_addr : addr_q;
        op_wdata = state_q == S_IDLE ? req_wdata : wdata_q;
        op_size  = state_q == S_IDLE ? req_size : size_q;
        op_err   = access_err(op_write, op_size, op_addr[2:0]) || op_addr[63:3] >= 61'(DEPTH_WORDS);
        idx      = op_addr[IW+2:3];
        raw      = mem_q[idx];
        merged   = raw;
        for (int i = 0; i < 8; i++) merged[8*i +: 8] = be[i] ? wsh[8*i +: 8] : raw[8*i +: 8];
    end
    dmem_lane_align u_align (
        .size    (op_size),
        .off     (op_addr[2:0]),
        .wdata   (op_wdata),
        .rword   (raw),
        .be      (be),
        .wdata_sh(wsh),
        .rdata   (rext)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                write_d = req_write;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                size_d  = req_size;
                cnt_d   = 4'(LATENCY - 1);
                state_d = LATENCY > 1 ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = cnt_d == 4'd0 ? S_RESP : S_WAIT;
            end
            default: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        commit = state_d == S_RESP && state_q != S_RESP;
        if (commit) begin
            rdata_d = (op_err || op_write) ? 64'd0 : rext;
            err_d   = op_err;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (commit && op_write && !op_err) mem_q[idx] <= merged;
        end
    end
    assign req_ready = state_q == S_IDLE;
    assign rsp_valid = state_q == S_RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign stall     = (state_q == S_IDLE && req_valid) || state_q == S_WAIT;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench with a byte-addressed reference memory, plus timing checks
// on LATENCY=1 and LATENCY=3 instances.
module tb_dmem_responder;
    localparam int DW  = 256;
    localparam int DWS = 16;
    localparam int LAT0 = 2;
    typedef struct {
        logic [63:0] rdata;
        bit          err;
        int          due;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset, v0, v1, v3, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        r0_ready, r0_valid, r0_err, r0_stall;
    logic        r1_ready, r1_valid, r1_err, r1_stall;
    logic        r3_ready, r3_valid, r3_err, r3_stall;
    logic [63:0] r0_rdata, r1_rdata, r3_rdata;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [7:0]  mem_m [8*DW];
    logic [2:0]  sz;
    logic [63:0] a;
    int          n, wi, off;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(LAT0)) u0 (
        .clk(clk), .reset(reset), .req_valid(v0), .req_ready(r0_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .rsp_valid(r0_valid),
        .rsp_rdata(r0_rdata), .rsp_err(r0_err), .stall(r0_stall));
    dmem_responder #(.DEPTH_WORDS(DWS), .LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_ready(r1_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .rsp_valid(r1_valid),
        .rsp_rdata(r1_rdata), .rsp_err(r1_err), .stall(r1_stall));
    dmem_responder #(.DEPTH_WORDS(DWS), .LATENCY(3)) u3 (
        .clk(clk), .reset(reset), .req_valid(v3), .req_ready(r3_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .rsp_valid(r3_valid),
        .rsp_rdata(r3_rdata), .rsp_err(r3_err), .stall(r3_stall));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Reference: byte-granular memory, widths from 1 << size[1:0]
    task automatic model(input bit w, input logic [63:0] addr, input logic [63:0] wd,
                         input logic [2:0] s, output logic [63:0] rd, output bit e);
        int nb;
        nb = 1 << s[1:0];
        rd = '0;
        e  = (addr % 64'(nb) != 0) || ((addr >> 3) >= 64'(DW)) || s == 3'd7 || (w && s >= 3'd4);
        if (e) return;
        if (w) begin
            for (int i = 0; i < nb; i++) mem_m[int'(addr) + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < nb; i++) rd[8*i +: 8] = mem_m[int'(addr) + i];
            if (!s[2] && nb < 8 && rd[8*nb-1]) rd = rd | (~64'd0 << (8*nb));
        end
    endtask

    task automatic issue(input bit w, input logic [63:0] addr, input logic [63:0] wd,
                         input logic [2:0] s, input bit push);
        exp_t e;
        int   g;
        g = 0;
        @(negedge clk);
        while (!r0_ready) begin
            @(negedge clk);
            g++;
            if (g > 100) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: req_ready stuck at %b", r0_ready);
                return;
            end
        end
        req_write = w;
        req_addr  = addr;
        req_wdata = wd;
        req_size  = s;
        v0        = 1'b1;
        if (push) begin
            model(w, addr, wd, s, e.rdata, e.err);
            e.due = cyc + LAT0;
            exp_q.push_back(e);
        end
        #1 chk("stall_on_req", r0_stall, 1);
        @(posedge clk);
        #1 v0 = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses missing, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (r0_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: rdata=%h err=%b at cycle %0d, want no response", r0_rdata, r0_err, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (r0_rdata !== mon_e.rdata || r0_err !== mon_e.err || cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL rsp: got rdata=%h err=%b cycle=%0d, want rdata=%h err=%b cycle=%0d",
                             r0_rdata, r0_err, cyc, mon_e.rdata, mon_e.err, mon_e.due);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; v0 = 1'b0; v1 = 1'b0; v3 = 1'b0;
        req_write = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0;
        foreach (mem_m[i]) mem_m[i] = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_ready", r0_ready, 1);
        chk("rst_valid", r0_valid, 0);
        chk("rst_rdata", r0_rdata, 0);
        chk("rst_err", r0_err, 0);
        chk("rst_stall", r0_stall, 0);
        issue(1, 64'h10, 64'h1122334455667788, 3'b011, 1);
        issue(0, 64'h10, 64'h0, 3'b011, 1);
        issue(1, 64'h13, 64'h80, 3'b000, 1);
        issue(0, 64'h13, 64'h0, 3'b000, 1);
        issue(0, 64'h13, 64'h0, 3'b100, 1);
        issue(0, 64'h10, 64'h0, 3'b011, 1);
        issue(0, 64'h12, 64'h0, 3'b010, 1);
        issue(1, 64'(8*DW), 64'hDEADBEEF, 3'b011, 1);
        issue(0, 64'(8*DW-8), 64'h0, 3'b011, 1);
        issue(1, 64'h18, 64'hFFFF, 3'b101, 1);
        issue(0, 64'h18, 64'h0, 3'b111, 1);
        for (int k = 0; k < 300; k++) begin
            sz  = 3'($urandom_range(0, 7));
            n   = 1 << sz[1:0];
            wi  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DW)) : int'($urandom_range(0, 7));
            off = int'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) off = off & ~(n - 1);
            a = 64'(wi) * 64'd8 + 64'(off);
            if ($urandom_range(0, 49) == 0) a = {$urandom, $urandom};
            issue($urandom_range(0, 1) == 1, a, {$urandom, $urandom}, sz, 1);
        end
        issue(1, 64'h20, 64'hCAFEF00D12345678, 3'b011, 1);
        drain();
        issue(1, 64'h20, 64'h5555AAAA5555AAAA, 3'b011, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        foreach (mem_m[i]) mem_m[i] = 8'h00;
        #1;
        chk("wait_rst_ready", r0_ready, 1);
        chk("wait_rst_valid", r0_valid, 0);
        chk("wait_rst_rdata", r0_rdata, 0);
        chk("wait_rst_err", r0_err, 0);
        chk("wait_rst_stall", r0_stall, 0);
        issue(0, 64'h20, 64'h0, 3'b011, 1);
        issue(0, 64'h10, 64'h0, 3'b011, 1);
        drain();
        // LATENCY=1: store then load, response one cycle after accept
        @(negedge clk);
        req_write = 1'b1; req_addr = 64'h8; req_wdata = 64'hA5A5000012345678; req_size = 3'b011;
        v1 = 1'b1;
        #1 chk("l1_st_stall", r1_stall, 1);
        @(negedge clk);
        v1 = 1'b0;
        #1;
        chk("l1_st_valid", r1_valid, 1);
        chk("l1_st_err", r1_err, 0);
        chk("l1_st_rdata", r1_rdata, 0);
        chk("l1_st_stall_resp", r1_stall, 0);
        @(negedge clk);
        req_write = 1'b0;
        v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        #1;
        chk("l1_ld_valid", r1_valid, 1);
        chk("l1_ld_rdata", r1_rdata, 64'hA5A5000012345678);
        chk("l1_ld_err", r1_err, 0);
        @(negedge clk);
        v1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("l1_hold_stall", r1_stall, (i % 2 == 0) ? 1 : 0);
            chk("l1_hold_ready", r1_ready, (i % 2 == 0) ? 1 : 0);
            chk("l1_hold_valid", r1_valid, (i % 2 == 1) ? 1 : 0);
            if (i % 2 == 1) chk("l1_hold_rdata", r1_rdata, 64'hA5A5000012345678);
            @(negedge clk);
        end
        v1 = 1'b0;
        // LATENCY=3 with req_valid held: accept every 4 cycles, stall low only in RESP
        @(negedge clk);
        v3 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("l3_hold_stall", r3_stall, (i % 4 != 3) ? 1 : 0);
            chk("l3_hold_ready", r3_ready, (i % 4 == 0) ? 1 : 0);
            chk("l3_hold_valid", r3_valid, (i % 4 == 3) ? 1 : 0);
            if (i % 4 == 3) chk("l3_hold_rdata", r3_rdata, 0);
            @(negedge clk);
        end
        v3 = 1'b0;
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
